// File: rtl/fma_ctrl_pkg.sv
// Shared types and constants for the fma16 issue controller.
// Datapath widths follow the fp16 layout (1 sign, NE exponent, NF fraction bits).
package fma_ctrl_pkg;

    localparam int unsigned NF    = 10;
    localparam int unsigned NE    = 5;
    localparam int unsigned FpW   = 1 + NE + NF;
    localparam int unsigned FlagW = 4;
    localparam int unsigned OpW   = 4;

    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RD  = 2'b10;
    localparam logic [1:0] RM_RU  = 2'b11;

    localparam int unsigned FlagInvalid   = 3;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagInexact   = 0;

    typedef enum logic [0:0] {
        StIdle,
        StExec
    } fma_state_e;

    typedef struct packed {
        logic mul;
        logic add;
        logic negp;
        logic negz;
    } fma_op_t;

endpackage

// File: rtl/fma_issue_ctrl_if.sv
// Requester/response handshakes plus the shared fma16 datapath connection.
// master is the requester/datapath side, slave is the issue controller.
interface fma_issue_ctrl_if #(
    parameter int unsigned NREQ = 2
);
    import fma_ctrl_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*FpW-1:0]   req_x;
    logic [NREQ*FpW-1:0]   req_y;
    logic [NREQ*FpW-1:0]   req_z;
    logic [NREQ*OpW-1:0]   req_op;
    logic [NREQ*2-1:0]     req_rm;

    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [NREQ*FpW-1:0]   rsp_result;
    logic [NREQ*FlagW-1:0] rsp_flags;

    logic [FpW-1:0]        fma_x;
    logic [FpW-1:0]        fma_y;
    logic [FpW-1:0]        fma_z;
    logic                  fma_mul;
    logic                  fma_add;
    logic                  fma_negp;
    logic                  fma_negz;
    logic [1:0]            fma_roundmode;
    logic [FpW-1:0]        fma_result;
    logic [FlagW-1:0]      fma_flags;

    modport master (
        output req_valid, req_x, req_y, req_z, req_op, req_rm, rsp_ready,
        output fma_result, fma_flags,
        input  req_ready, rsp_valid, rsp_result, rsp_flags,
        input  fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_op, req_rm, rsp_ready,
        input  fma_result, fma_flags,
        output req_ready, rsp_valid, rsp_result, rsp_flags,
        output fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode
    );

endinterface

// File: rtl/fma_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first eligible
// requester found searching upward from rr_ptr (wrapping).
module fma_rr_arb #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         grant
);

    int idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % int'(NREQ);
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fma_issue_ctrl.sv
// Issue controller sharing one fma16 datapath between NREQ requesters:
// arbitrate, launch operands, wait LAT cycles, capture into per-requester response slots.
module fma_issue_ctrl
    import fma_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned LAT  = 2
) (
    input  logic            clk,
    input  logic            reset,
    fma_issue_ctrl_if.slave bus,
    output logic            busy
);

    localparam int unsigned PtrW = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(LAT) + 1;

    fma_state_e            state;
    logic [PtrW-1:0]       rr_ptr;
    logic [PtrW-1:0]       owner;
    logic [PtrW-1:0]       grant_idx;
    logic [CntW-1:0]       cnt;
    logic [NREQ-1:0]       eligible;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       rsp_valid_q;
    logic [NREQ*FpW-1:0]   rsp_result_q;
    logic [NREQ*FlagW-1:0] rsp_flags_q;
    logic [FpW-1:0]        fma_x_q;
    logic [FpW-1:0]        fma_y_q;
    logic [FpW-1:0]        fma_z_q;
    fma_op_t               op_q;
    logic [1:0]            rm_q;

    // A slot being drained on this edge is free for a new grant.
    assign eligible = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);

    fma_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .eligible(eligible),
        .rr_ptr  (rr_ptr),
        .grant   (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) grant_idx = PtrW'(i);
        end
    end

    assign bus.req_ready = (state == StIdle) ? grant : '0;
    assign busy          = (state != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            fma_x_q      <= '0;
            fma_y_q      <= '0;
            fma_z_q      <= '0;
            op_q         <= '0;
            rm_q         <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_q & ~bus.rsp_ready;
            case (state)
                StIdle: begin
                    if (|grant) begin
                        fma_x_q <= bus.req_x[grant_idx*FpW +: FpW];
                        fma_y_q <= bus.req_y[grant_idx*FpW +: FpW];
                        fma_z_q <= bus.req_z[grant_idx*FpW +: FpW];
                        op_q    <= bus.req_op[grant_idx*OpW +: OpW];
                        rm_q    <= bus.req_rm[grant_idx*2 +: 2];
                        owner   <= grant_idx;
                        cnt     <= '0;
                        rr_ptr  <= (grant_idx == PtrW'(NREQ - 1)) ? '0 : grant_idx + PtrW'(1);
                        state   <= StExec;
                    end
                end
                StExec: begin
                    cnt <= cnt + CntW'(1);
                    // Capture overrides a same-edge pop of the owner's slot.
                    if (cnt == CntW'(LAT - 1)) begin
                        rsp_result_q[owner*FpW +: FpW]     <= bus.fma_result;
                        rsp_flags_q[owner*FlagW +: FlagW]  <= bus.fma_flags;
                        rsp_valid_q[owner]                 <= 1'b1;
                        state                              <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_flags     = rsp_flags_q;
    assign bus.fma_x         = fma_x_q;
    assign bus.fma_y         = fma_y_q;
    assign bus.fma_z         = fma_z_q;
    assign bus.fma_mul       = op_q.mul;
    assign bus.fma_add       = op_q.add;
    assign bus.fma_negp      = op_q.negp;
    assign bus.fma_negz      = op_q.negz;
    assign bus.fma_roundmode = rm_q;

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Bench for fma_issue_ctrl with a stand-in fma16 datapath and a per-requester scoreboard.
module tb_fma_issue_ctrl;
    import fma_ctrl_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned LAT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] dp_q;
    logic [19:0] sb0[$];
    logic [19:0] sb1[$];
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] blk;
    logic [19:0] got[NREQ];
    logic [19:0] exp_v[NREQ];

    fma_issue_ctrl_if #(.NREQ(NREQ)) bus ();

    fma_issue_ctrl #(
        .NREQ(NREQ),
        .LAT (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Known fp16 cases from real arithmetic; any other input gets a deterministic scramble.
    function automatic logic [19:0] dp_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z, input logic [3:0] op,
                                             input logic [1:0] rm);
        if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && op == 4'b1100 && rm == RM_RNE)
            return {16'h4200, 4'b0000};
        if (x == 16'h7BFF && y == 16'h4000 && z == 16'h0000 && op == 4'b1000)
            return (rm == RM_RZ || rm == RM_RD) ? {16'h7BFF, 4'b0101} : {16'h7C00, 4'b0101};
        return {x ^ {y[10:0], y[15:11]} ^ ~z ^ {op, rm, 10'h0},
                x[3:0] ^ y[7:4] ^ z[11:8] ^ op};
    endfunction

    // Result becomes correct LAT-1 edges after the operand registers change.
    always @(posedge clk)
        dp_q <= dp_model(bus.fma_x, bus.fma_y, bus.fma_z,
                         {bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz},
                         bus.fma_roundmode);
    assign bus.fma_result = dp_q[19:4];
    assign bus.fma_flags  = dp_q[3:0];

    task automatic drive_req(input int i, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] z, input logic [3:0] op, input logic [1:0] rm);
        bus.req_valid[i]       = 1'b1;
        bus.req_x[16*i +: 16]  = x;
        bus.req_y[16*i +: 16]  = y;
        bus.req_z[16*i +: 16]  = z;
        bus.req_op[4*i +: 4]   = op;
        bus.req_rm[2*i +: 2]   = rm;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_z     = '0;
        bus.req_op    = '0;
        bus.req_rm    = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
    endtask

    // Called just after a negedge with inputs set; records handshakes, advances one cycle.
    task automatic step();
        #1;
        acc = bus.req_valid & bus.req_ready;
        pop = bus.rsp_valid & bus.rsp_ready;
        blk = acc & bus.rsp_valid & ~bus.rsp_ready;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (acc[i]) begin
                if (i == 0)
                    sb0.push_back(dp_model(bus.req_x[15:0], bus.req_y[15:0], bus.req_z[15:0],
                                           bus.req_op[3:0], bus.req_rm[1:0]));
                else
                    sb1.push_back(dp_model(bus.req_x[31:16], bus.req_y[31:16], bus.req_z[31:16],
                                           bus.req_op[7:4], bus.req_rm[3:2]));
            end
            if (pop[i]) begin
                got[i]   = {bus.rsp_result[16*i +: 16], bus.rsp_flags[4*i +: 4]};
                exp_v[i] = 'x;
                if (i == 0 && sb0.size() > 0) exp_v[i] = sb0.pop_front();
                if (i == 1 && sb1.size() > 0) exp_v[i] = sb1.pop_front();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result: got %h want 0", bus.rsp_result); end
        checks++; if (bus.rsp_flags !== 8'h0) begin errors++; $display("FAIL reset_rsp_flags: got %h want 0", bus.rsp_flags); end
        checks++; if ({bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_roundmode} !== 50'h0) begin
            errors++; $display("FAIL reset_fma_regs: got x=%h y=%h z=%h rm=%b want 0", bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_roundmode);
        end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
    endtask

    task automatic test_single();
        apply_reset();
        drive_req(0, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, RM_RNE);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        checks++; if ({bus.fma_x, bus.fma_y, bus.fma_z} !== {16'h3C00, 16'h4000, 16'h3C00}) begin
            errors++; $display("FAIL single_launch: got %h %h %h want 3c00 4000 3c00", bus.fma_x, bus.fma_y, bus.fma_z);
        end
        checks++; if ({bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz, bus.fma_roundmode} !== 6'b110001) begin
            errors++; $display("FAIL single_ctrl: got %b%b%b%b rm=%b want 1100 rm=01", bus.fma_mul, bus.fma_add, bus.fma_negp, bus.fma_negz, bus.fma_roundmode);
        end
        step();
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early: got %b want 00", bus.rsp_valid); end
        step();
        checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", bus.rsp_valid); end
        checks++; if ({bus.rsp_result[15:0], bus.rsp_flags[3:0]} !== {16'h4200, 4'b0000}) begin
            errors++; $display("FAIL single_result: got %h/%b want 4200/0000", bus.rsp_result[15:0], bus.rsp_flags[3:0]);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
        checks++; if (pop[0] !== 1'b1 || got[0] !== exp_v[0]) begin
            errors++; $display("FAIL single_pop: pop=%b got %h want %h", pop[0], got[0], exp_v[0]);
        end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_cleared: got %b want 00", bus.rsp_valid); end
        checks++; if (bus.fma_x !== 16'h3C00) begin errors++; $display("FAIL single_hold: got %h want 3c00", bus.fma_x); end
    endtask

    task automatic test_contention();
        apply_reset();
        bus.rsp_ready = 2'b11;
        drive_req(0, 16'h1234, 16'h5678, 16'h9ABC, 4'b1100, RM_RU);
        drive_req(1, 16'h4321, 16'h8765, 16'hCBA9, 4'b0100, RM_RD);
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL cont_first: got %b want 01", bus.req_ready); end
        step();
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL cont_exec_ready: got %b want 00", bus.req_ready); end
        step();
        step();
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL cont_second: got %b want 10", bus.req_ready); end
        step();
        checks++; if (pop[0] !== 1'b1 || got[0] !== exp_v[0]) begin
            errors++; $display("FAIL cont_pop0: pop=%b got %h want %h", pop[0], got[0], exp_v[0]);
        end
        checks++; if (bus.fma_x !== 16'h4321) begin errors++; $display("FAIL cont_owner1: got %h want 4321", bus.fma_x); end
        step();
        step();
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL cont_ptr_wrap: got %b want 01", bus.req_ready); end
        bus.req_valid = '0;
        step();
        checks++; if (pop[1] !== 1'b1 || got[1] !== exp_v[1]) begin
            errors++; $display("FAIL cont_pop1: pop=%b got %h want %h", pop[1], got[1], exp_v[1]);
        end
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [19:0] exp_b;
        apply_reset();
        drive_req(0, 16'h0A0A, 16'h1B1B, 16'h2C2C, 4'b1000, RM_RZ);
        step();
        drive_req(0, 16'h3D3D, 16'h4E4E, 16'h5F5F, 4'b0110, RM_RNE);
        exp_b = dp_model(16'h3D3D, 16'h4E4E, 16'h5F5F, 4'b0110, RM_RNE);
        step();
        step();
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_blocked%0d: got %b want 00", n, bus.req_ready); end
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy%0d: got %b want 0", n, busy); end
        end
        bus.rsp_ready = 2'b01;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 2'b00;
        checks++; if (pop[0] !== 1'b1 || got[0] !== exp_v[0]) begin
            errors++; $display("FAIL bp_pop: pop=%b got %h want %h", pop[0], got[0], exp_v[0]);
        end
        checks++; if (busy !== 1'b1 || bus.rsp_valid !== 2'b00) begin
            errors++; $display("FAIL bp_same_edge: busy=%b rsp_valid=%b want 1 00", busy, bus.rsp_valid);
        end
        step();
        step();
        checks++; if (bus.rsp_valid !== 2'b01 || {bus.rsp_result[15:0], bus.rsp_flags[3:0]} !== exp_b) begin
            errors++; $display("FAIL bp_second: valid=%b got %h want %h", bus.rsp_valid, {bus.rsp_result[15:0], bus.rsp_flags[3:0]}, exp_b);
        end
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_round_modes();
        logic [1:0]  rms[2];
        logic [19:0] want[2];
        rms[0] = RM_RNE; want[0] = {16'h7C00, 4'b0101};
        rms[1] = RM_RZ;  want[1] = {16'h7BFF, 4'b0101};
        apply_reset();
        for (int n = 0; n < 2; n++) begin
            drive_req(0, 16'h7BFF, 16'h4000, 16'h0000, 4'b1000, rms[n]);
            step();
            bus.req_valid = '0;
            step();
            step();
            checks++; if (bus.rsp_valid[0] !== 1'b1 || {bus.rsp_result[15:0], bus.rsp_flags[3:0]} !== want[n]) begin
                errors++; $display("FAIL ovf_rm%b: valid=%b got %h want %h", rms[n], bus.rsp_valid[0], {bus.rsp_result[15:0], bus.rsp_flags[3:0]}, want[n]);
            end
            bus.rsp_ready = 2'b01;
            step();
            bus.rsp_ready = 2'b00;
        end
    endtask

    task automatic test_reset_mid_exec();
        apply_reset();
        bus.rsp_ready = 2'b00;
        drive_req(1, 16'hABCD, 16'h1357, 16'h2468, 4'b1100, RM_RNE);
        step();
        bus.req_valid = '0;
        step();
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || bus.fma_x !== 16'h0000) begin
            errors++; $display("FAIL mid_reset: busy=%b fma_x=%h want 0 0000", busy, bus.fma_x);
        end
        @(negedge clk);
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
        for (int n = 0; n < 5; n++) begin
            step();
            checks++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_no_rsp%0d: rsp_valid=%b busy=%b want 00 0", n, bus.rsp_valid, busy);
            end
        end
    endtask

    task automatic test_soak();
        int          ops = 0;
        int          cycles = 0;
        logic        prev_busy = 1'b0;
        logic [53:0] prev_fma = '0;
        logic [53:0] cur_fma;
        apply_reset();
        while (ops < 3000 && cycles < 40000) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if ($urandom_range(0, 3) != 0)
                    drive_req(i, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));
                else
                    bus.req_valid[i] = 1'b0;
            end
            bus.rsp_ready = 2'($urandom);
            step();
            cycles++;
            ops += $countones(acc);
            if (acc != '0) begin
                checks++; if (blk !== 2'b00) begin errors++; $display("FAIL soak_full_grant: blocked=%b want 00", blk); end
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (pop[i]) begin
                    checks++; if (got[i] !== exp_v[i]) begin
                        errors++; $display("FAIL soak_rsp%0d: got %h want %h", i, got[i], exp_v[i]);
                    end
                end
            end
            cur_fma = {bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_mul, bus.fma_add, bus.fma_negp,
                       bus.fma_negz, bus.fma_roundmode};
            if (busy && prev_busy) begin
                checks++; if (cur_fma !== prev_fma) begin
                    errors++; $display("FAIL soak_fma_stable: got %h want %h", cur_fma, prev_fma);
                end
            end
            prev_busy = busy;
            prev_fma  = cur_fma;
        end
        checks++; if (ops < 3000) begin errors++; $display("FAIL soak_budget: got %0d ops want 3000", ops); end
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        for (int n = 0; n < 10; n++) begin
            step();
            for (int i = 0; i < int'(NREQ); i++) begin
                if (pop[i]) begin
                    checks++; if (got[i] !== exp_v[i]) begin
                        errors++; $display("FAIL drain_rsp%0d: got %h want %h", i, got[i], exp_v[i]);
                    end
                end
            end
        end
        checks++; if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++; $display("FAIL soak_lost: pending %0d/%0d want 0/0", sb0.size(), sb1.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_round_modes();
        test_reset_mid_exec();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
